// File: rtl/adda_adc_capture.sv
// ----------------------------------------------------------------------------
// adda_adc_capture
//
// Pre/post-trigger capture of an 8-bit ADC stream into a circular buffer,
// followed by a chronological readout of the whole buffer.
//
// A capture is started by arm in IDLE. Samples are stored on decimation
// strobes (one every decim+1 cycles). The first PRE strobes fill the
// pre-trigger history, then the block hunts for a level crossing (rising or
// falling, selected at arm time) while continuing to overwrite the ring.
// The trigger sample plus DEPTH-PRE-1 further samples complete the capture.
// Readout then starts PRE entries before the trigger address, so read index
// PRE is always the trigger sample.
//
// Optional feature macro: FORCE_TRIG_EN adds the force_trig input, which
// forces a trigger on any strobe while waiting for the trigger.
//
// Parameters
//   AW          buffer address width, DEPTH = 2**AW samples
//   PRE         pre-trigger sample count, 1 .. DEPTH-2
//
// Ports
//   clkin       ADDA sample clock (sole clock)
//   reset       synchronous active-high reset
//   adc_data    raw ADC sample (unsigned), registered before use
//   arm         one-cycle capture start, honoured only in IDLE
//   trig_level  trigger threshold (compared live, not latched)
//   trig_rise   1 = rising-edge trigger, 0 = falling-edge (latched at arm)
//   decim       store one sample every decim+1 cycles (latched at arm)
//   force_trig  (FORCE_TRIG_EN only) force a trigger on a waiting strobe
//   rd_en       readout request, one sample per asserted cycle in DONE
//   rd_data     readout sample, valid with rd_valid
//   rd_valid    one cycle after an accepted rd_en
//   rd_last     marks the DEPTH-th readout sample
//   busy        capture in progress (registered)
//   done        capture complete, buffer readable (registered)
// ----------------------------------------------------------------------------
module adda_adc_capture #(
    parameter int AW  = 10,
    parameter int PRE = 256
) (
    input  logic       clkin,
    input  logic       reset,
    input  logic [7:0] adc_data,
    input  logic       arm,
    input  logic [7:0] trig_level,
    input  logic       trig_rise,
    input  logic [7:0] decim,
`ifdef FORCE_TRIG_EN
    input  logic       force_trig,
`endif
    input  logic       rd_en,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       rd_last,
    output logic       busy,
    output logic       done
);

    localparam int DEPTH = 1 << AW;
    localparam int CW    = AW + 1;

    // Sample-count compare points: the strobe that sees the counter at these
    // values writes the final sample of its phase.
    localparam logic [CW-1:0] PRE_LAST    = CW'(PRE - 1);
    localparam logic [CW-1:0] POST_LAST   = CW'(DEPTH - PRE - 1);
    localparam logic [AW-1:0] PRE_OFS     = AW'(PRE);
    localparam logic [AW-1:0] RD_LAST_IDX = AW'(DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_WAIT_TRIG,
        S_POST,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [7:0]    adc_q;
    logic [7:0]    prev_q;
    logic [7:0]    dec_lat;
    logic [7:0]    dec_cnt;
    logic          rise_lat;
    logic [AW-1:0] wptr;
    logic [CW-1:0] scnt;
    logic [AW-1:0] taddr;
    logic [AW-1:0] rptr;
    logic [AW-1:0] rd_cnt;

    // Sample buffer: deliberately never reset so the last capture survives
    // a reset or a new arm until it is overwritten.
    logic [7:0] mem [DEPTH];

    logic in_capture;
    logic strobe;
    logic edge_hit;
    logic trig;
    logic rd_accept;
    logic rd_final;

    // ------------------------------------------------------------------
    // Datapath qualifiers
    // ------------------------------------------------------------------
    always_comb begin
        in_capture = (state == S_PRE) || (state == S_WAIT_TRIG) || (state == S_POST);
        strobe     = in_capture && (dec_cnt == dec_lat);

        // prev_q is the previously strobed sample, so the crossing is judged
        // between stored samples, not between raw adjacent clock cycles.
        edge_hit = 1'b0;
        if (rise_lat)
            edge_hit = (prev_q <  trig_level) && (adc_q >= trig_level);
        else
            edge_hit = (prev_q >= trig_level) && (adc_q <  trig_level);
`ifdef FORCE_TRIG_EN
        if (force_trig)
            edge_hit = 1'b1;
`endif
        trig = (state == S_WAIT_TRIG) && strobe && edge_hit;

        rd_accept = (state == S_DONE) && rd_en;
        rd_final  = rd_accept && (rd_cnt == RD_LAST_IDX);
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (arm)
                    state_nxt = S_PRE;
            end
            S_PRE: begin
                if (strobe && (scnt == PRE_LAST))
                    state_nxt = S_WAIT_TRIG;
            end
            S_WAIT_TRIG: begin
                if (trig)
                    state_nxt = S_POST;
            end
            S_POST: begin
                if (strobe && (scnt == POST_LAST))
                    state_nxt = S_DONE;
            end
            S_DONE: begin
                // Leave on the accept of the final read so that done drops
                // in the same cycle its rd_valid/rd_last appear.
                if (rd_final)
                    state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State and control registers
    // ------------------------------------------------------------------
    always_ff @(posedge clkin) begin
        if (reset) begin
            state    <= S_IDLE;
            adc_q    <= '0;
            prev_q   <= '0;
            dec_lat  <= '0;
            dec_cnt  <= '0;
            rise_lat <= 1'b0;
            wptr     <= '0;
            scnt     <= '0;
            taddr    <= '0;
            rptr     <= '0;
            rd_cnt   <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state <= state_nxt;
            adc_q <= adc_data;

            // Status flags follow the next state so they line up with it.
            busy <= (state_nxt == S_PRE) || (state_nxt == S_WAIT_TRIG) ||
                    (state_nxt == S_POST);
            done <= (state_nxt == S_DONE);

            if ((state == S_IDLE) && arm) begin
                dec_lat  <= decim;
                rise_lat <= trig_rise;
                wptr     <= '0;
                scnt     <= '0;
                dec_cnt  <= '0;
            end else if (in_capture) begin
                dec_cnt <= strobe ? 8'd0 : dec_cnt + 8'd1;
                if (strobe) begin
                    wptr   <= wptr + 1'b1;
                    prev_q <= adc_q;
                    case (state)
                        S_PRE:       scnt <= scnt + 1'b1;
                        S_WAIT_TRIG: begin
                            if (trig) begin
                                // Trigger sample is post-sample 1.
                                taddr <= wptr;
                                scnt  <= CW'(1);
                            end
                        end
                        S_POST:      scnt <= scnt + 1'b1;
                        default:     scnt <= scnt;
                    endcase
                end
            end

            // Oldest sample of the finished capture sits PRE entries before
            // the trigger, modulo the ring size.
            if ((state == S_POST) && (state_nxt == S_DONE)) begin
                rptr   <= taddr - PRE_OFS;
                rd_cnt <= '0;
            end

            rd_valid <= rd_accept;
            rd_last  <= rd_final;
            if (rd_accept) begin
                rd_data <= mem[rptr];
                rptr    <= rptr + 1'b1;
                rd_cnt  <= rd_cnt + 1'b1;
            end
        end
    end

    // Buffer write port, kept free of reset so it maps onto block RAM.
    always_ff @(posedge clkin) begin
        if (strobe)
            mem[wptr] <= adc_q;
    end

endmodule

// File: tb/tb_adda_adc_capture.sv
// ----------------------------------------------------------------------------
// tb_adda_adc_capture
//
// Directed bench for adda_adc_capture with AW=10, PRE=256. Inputs are driven
// on the falling edge; a scoreboard queue holds the expected readout samples
// (pushed when rd_en is driven) and a monitor pops them when rd_valid appears.
// Expected readout values follow from the ramp stimulus: with a ramp starting
// at a known value, the trigger sample and its neighbours are known in closed
// form.
// ----------------------------------------------------------------------------
module tb_adda_adc_capture;

    localparam int AW    = 10;
    localparam int PRE   = 256;
    localparam int DEPTH = 1 << AW;

    logic       clkin      = 1'b0;
    logic       reset      = 1'b1;
    logic [7:0] adc_data   = 8'd0;
    logic       arm        = 1'b0;
    logic [7:0] trig_level = 8'd100;
    logic       trig_rise  = 1'b1;
    logic [7:0] decim      = 8'd0;
    logic       rd_en      = 1'b0;
`ifdef FORCE_TRIG_EN
    logic       force_trig = 1'b0;
    int         force_at   = -1;
`endif
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       rd_last;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;
    bit ramp_on = 1'b1;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } rd_exp_t;

    rd_exp_t sb[$];

    always #5 clkin = ~clkin;

    adda_adc_capture #(.AW(AW), .PRE(PRE)) dut (
        .clkin      (clkin),
        .reset      (reset),
        .adc_data   (adc_data),
        .arm        (arm),
        .trig_level (trig_level),
        .trig_rise  (trig_rise),
        .decim      (decim),
`ifdef FORCE_TRIG_EN
        .force_trig (force_trig),
`endif
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .rd_last    (rd_last),
        .busy       (busy),
        .done       (done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // One clock: advance to the falling edge, step the ramp.
    task automatic tick();
        @(negedge clkin);
        if (ramp_on)
            adc_data = adc_data + 8'd1;
    endtask

    // Arm with the ramp sitting at a0 on the arming edge. Returns on the
    // falling edge of the first busy cycle.
    task automatic arm_pulse(input logic [7:0] a0);
        tick();
        adc_data = a0;
        arm      = 1'b1;
        tick();
        arm      = 1'b0;
    endtask

    // Arm, then count busy cycles until the capture ends. A second arm is
    // pulsed at busy cycle arm_again (ignored if <= 0).
    task automatic capture(input logic [7:0] a0, input int arm_again, output int nbusy);
        arm_pulse(a0);
        nbusy = 0;
        for (int c = 0; c < 20000; c++) begin
            if (busy !== 1'b1)
                break;
            nbusy++;
            if (nbusy == 1)
                chk("done_low_while_busy", {31'd0, done}, 32'd0);
            arm = (nbusy == arm_again);
`ifdef FORCE_TRIG_EN
            force_trig = (nbusy == force_at);
`endif
            tick();
        end
        arm = 1'b0;
`ifdef FORCE_TRIG_EN
        force_trig = 1'b0;
`endif
        chk("capture_busy_end", {31'd0, busy}, 32'd0);
        chk("capture_done",     {31'd0, done}, 32'd1);
    endtask

    // Read the full buffer with rd_en held high; sample i is
    // (base + step*i) mod 256. extra keeps rd_en high past the last read.
    task automatic readout(input int base, input int step, input int extra);
        rd_exp_t e;
        for (int i = 0; i < DEPTH; i++) begin
            rd_en  = 1'b1;
            e.data = 8'((base + step * i) & 255);
            e.last = (i == DEPTH - 1);
            sb.push_back(e);
            tick();
        end
        for (int i = 0; i < extra; i++)
            tick();
        rd_en = 1'b0;
        tick();
        tick();
        chk("scoreboard_drained", sb.size(), 32'd0);
    endtask

    // Monitor: rd_valid must appear exactly when an expected read is pending.
    always @(posedge clkin) begin
        rd_exp_t e;
        #1;
        if (mon_en) begin
            chk("rd_valid", {31'd0, rd_valid}, {31'd0, sb.size() != 0});
            if (rd_valid === 1'b1 && sb.size() != 0) begin
                e = sb.pop_front();
                chk("rd_data", {24'd0, rd_data}, {24'd0, e.data});
                chk("rd_last", {31'd0, rd_last}, {31'd0, e.last});
                chk("done_at_read", {31'd0, done}, {31'd0, !e.last});
            end
        end
    end

    initial begin
        int nb;

        repeat (3) tick();
        chk("rst_rd_data",  {24'd0, rd_data}, 32'd0);
        chk("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
        chk("rst_rd_last",  {31'd0, rd_last}, 32'd0);
        chk("rst_busy",     {31'd0, busy}, 32'd0);
        chk("rst_done",     {31'd0, done}, 32'd0);
        reset  = 1'b0;
        mon_en = 1'b1;

        // rd_en in IDLE must not produce reads.
        rd_en = 1'b1;
        repeat (4) tick();
        rd_en = 1'b0;
        tick();

        // Rising trigger at 100, ramp from 0: trigger is at index 256.
        trig_rise = 1'b1;
        decim     = 8'd0;
        capture(8'd0, -1, nb);
        readout(100, 1, 0);

        // Falling trigger fires on the 255->0 wrap.
        trig_rise = 1'b0;
        capture(8'd200, -1, nb);
        readout(0, 1, 0);

        // decim=3 from a0=6: stored samples are 9+4k, first >= 100 is 101.
        trig_rise = 1'b1;
        decim     = 8'd3;
        capture(8'd6, -1, nb);
        readout(101, 4, 0);
        decim = 8'd0;

        // Reset mid-POST, with arm and rd_en asserted alongside it.
        arm_pulse(8'd90);
        repeat (500) tick();
        chk("busy_before_reset", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        arm   = 1'b1;
        rd_en = 1'b1;
        tick();
        reset = 1'b0;
        arm   = 1'b0;
        rd_en = 1'b0;
        chk("post_rst_busy",     {31'd0, busy}, 32'd0);
        chk("post_rst_done",     {31'd0, done}, 32'd0);
        chk("post_rst_rd_valid", {31'd0, rd_valid}, 32'd0);
        chk("post_rst_rd_data",  {24'd0, rd_data}, 32'd0);
        chk("post_rst_rd_last",  {31'd0, rd_last}, 32'd0);
        rd_en = 1'b1;
        repeat (3) tick();
        rd_en = 1'b0;
        tick();
        chk("idle_after_rst", {31'd0, busy}, 32'd0);
        // From a0=90 the trigger is stored sample 266: 267+767 busy cycles.
        capture(8'd90, -1, nb);
        chk("busy_cycles_after_rst", nb, 32'd1034);
        readout(100, 1, 0);

        // arm in WAIT_TRIG is ignored: from a0=110 trigger is sample 502,
        // so busy lasts 503+767 cycles despite the second arm at cycle 400.
        capture(8'd110, 400, nb);
        chk("busy_cycles_arm_in_wait", nb, 32'd1270);
        readout(100, 1, 5);

`ifdef FORCE_TRIG_EN
        // Flat input never crosses the level; only force_trig can finish.
        ramp_on  = 1'b0;
        force_at = 300;
        capture(8'd50, -1, nb);
        readout(50, 0, 0);
        ramp_on  = 1'b1;
`endif

        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/adda_adc_capture.md
ADDA_ADC_CAPTURE -- requirements
Module: adda_adc_capture

Interface
REQ-001 Parameters are as follows.
- AW, default 10: buffer address width; buffer depth is DEPTH = 2^AW samples.
- PRE, default 256: number of pre-trigger samples; the legal range is 1 .. DEPTH-2.
REQ-002 Ports are as follows.
- clkin  in  1: ADDA sample clock from the ADDA PLL. This is the only clock.
- reset  in  1: synchronous, active-high reset.
- adc_data  in  8: ADC parallel sample, unsigned.
- arm  in  1: one-cycle request to start a capture.
- trig_level  in  8: trigger threshold.
- trig_rise  in  1: 1 selects rising-edge trigger; 0 selects falling-edge trigger.
- decim  in  8: store one sample every decim+1 cycles.
- rd_en  in  1: readout request, one sample per asserted cycle.
- rd_data  out  8: readout sample.
- rd_valid  out  1: rd_data is valid this cycle.
- rd_last  out  1: marks the final (DEPTH-th) readout sample.
- busy  out  1: capture is in progress.
- done  out  1: capture is complete and the buffer is readable.
REQ-003 When FORCE_TRIG_EN is defined, there is an extra port force_trig  in  1, which forces a trigger.

Function
REQ-010 adc_data SHALL be registered once (adc_q) before any use; all trigger compares and buffer writes use adc_q.
REQ-011 FSM states are IDLE, PRE, WAIT_TRIG, POST, DONE; busy = PRE|WAIT_TRIG|POST and done = DONE, both registered.
REQ-012 In IDLE, arm=1 SHALL latch decim and trig_rise, clear the write pointer, the sample counter and the decimation counter, then enter PRE. arm SHALL be ignored in every other state.
REQ-013 The decimation counter increments every cycle while busy. A strobe fires when counter==latched decim, and the counter then wraps to 0. decim=0 gives a strobe every cycle.
REQ-014 Each strobe in PRE, WAIT_TRIG or POST SHALL write adc_q to buffer[wptr] and then increment wptr modulo DEPTH (wrap-around).
REQ-015 PRE: after PRE strobes, enter WAIT_TRIG. No trigger detection occurs in PRE.
REQ-016 WAIT_TRIG trigger conditions, evaluated on strobes only, comparing the current sample cur with prev (the previous strobed sample, including the last PRE sample):
- rising: prev < trig_level and cur >= trig_level;
- falling: prev >= trig_level and cur < trig_level.
REQ-017 On a trigger, the trigger sample is written, its address is latched as taddr, and the FSM enters POST. The trigger sample counts as post-sample 1.
REQ-018 POST: when DEPTH-PRE post-samples have been written (trigger sample included), enter DONE.
REQ-019 DONE readout:
- The read pointer starts at (taddr - PRE) mod DEPTH.
- Each rd_en=1 cycle reads one sample and increments the pointer modulo DEPTH.
- rd_valid is asserted exactly 1 cycle after the accepted rd_en, with rd_data holding the sample.
REQ-020 Readout order is chronological. The sample at readout index PRE (0-based) is the trigger sample.
REQ-021 The DEPTH-th accepted read SHALL assert rd_last together with its rd_valid. The FSM returns to IDLE on that rd_valid cycle, and done is deasserted in the same cycle.
REQ-022 rd_en SHALL be ignored outside DONE, and ignored after the DEPTH-th read has been accepted. rd_valid stays 0 in those cases.
REQ-023 Buffer contents SHALL NOT be cleared by a new arm or by reset. Readout always reflects the latest completed capture.

Reset
REQ-030 reset=1 at a rising clkin edge SHALL force the following in the next cycle, from any state including mid-capture or mid-readout:
- state IDLE;
- wptr, read pointer, counters and taddr = 0;
- rd_data = 0, rd_valid = 0, rd_last = 0, busy = 0, done = 0.
REQ-031 reset SHALL dominate arm, rd_en and force_trig in the same cycle.

Configuration
REQ-040 Macro FORCE_TRIG_EN behaviour:
- When defined, force_trig=1 on a WAIT_TRIG strobe cycle is treated as a trigger regardless of level or edge.
- force_trig is ignored in all other states and on non-strobe cycles.
- When undefined, the port and its logic are absent, and only level/edge triggering exists.

Verification
REQ-050 AW=10, PRE=256, decim=0, adc_data = ramp (+1 per cycle, wrapping at 256), trig_level=100, trig_rise=1, arm -> busy until DONE; 1024 reads return consecutive values; read index 256 = 100; rd_last on read 1024; done falls on that cycle.
REQ-051 Same ramp, trig_rise=0, trig_level=100 -> trigger on the wrap 255->0 (prev 255 >= 100, cur 0 < 100); read index 256 = 0.
REQ-052 decim=3, ramp, trig_level=100 -> consecutive readout values differ by 4 (mod 256); read index 256 is the first stored value >= 100.
REQ-053 Reset asserted mid-POST -> next cycle busy=0, done=0; rd_en pulses give rd_valid=0; a fresh arm then completes a normal capture.
REQ-054 arm during WAIT_TRIG is ignored (wptr continues); rd_en in IDLE gives no rd_valid; rd_en held high in DONE gives rd_valid on 1024 consecutive cycles, then rd_valid=0.
REQ-055 With FORCE_TRIG_EN defined, constant adc_data=50, trig_level=100, force_trig pulsed in WAIT_TRIG -> DONE is reached; all 1024 reads return 50.
